// File: rtl/decode_stage.sv
// ID stage of the RV32I pipeline: control decode, immediate extension, register file, ID/EX register.
// RF_BYPASS_EN: write RF on rising edge with a read bypass; otherwise write on the falling edge.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            FlushE,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic            ALUSrcE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE
);

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic [2:0]      alu_ctrl;
    logic            alu_src;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } id_ex_t;

  logic [6:0] op;
  logic [2:0] f3;
  logic       f7b5;

  assign op   = InstrD[6:0];
  assign f3   = InstrD[14:12];
  assign f7b5 = InstrD[30];
  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];

  logic       reg_write, mem_write, jump, branch, alu_src;
  logic [1:0] result_src, imm_src, alu_op;
  logic [2:0] alu_ctrl;

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    result_src = 2'b00;
    imm_src    = 2'b00;
    alu_op     = 2'b00;
    unique case (1'b1)
      op == 7'b0000011: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
      end
      op == 7'b0100011: begin
        mem_write = 1'b1;
        imm_src   = 2'b01;
        alu_src   = 1'b1;
      end
      op == 7'b0110011: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      op == 7'b0010011: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b10;
      end
      op == 7'b1100011: begin
        branch  = 1'b1;
        imm_src = 2'b10;
        alu_op  = 2'b01;
      end
      op == 7'b1101111: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        imm_src    = 2'b11;
        result_src = 2'b10;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_ctrl = 3'b000;
    unique case (alu_op)
      2'b01:   alu_ctrl = 3'b001;
      2'b10: begin
        unique case (f3)
          3'b000:  alu_ctrl = (op[5] & f7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl = 3'b101;
          3'b110:  alu_ctrl = 3'b011;
          3'b111:  alu_ctrl = 3'b010;
          default: alu_ctrl = 3'b000;
        endcase
      end
      default: alu_ctrl = 3'b000;
    endcase
  end

  logic [XLEN-1:0] imm;

  always_comb begin
    unique case (imm_src)
      2'b00: imm = {{20{InstrD[31]}}, InstrD[31:20]};
      2'b01: imm = {{20{InstrD[31]}}, InstrD[31:25],
                    InstrD[11:7]};
      2'b10: imm = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                    InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm = {{11{InstrD[31]}}, InstrD[31],
                      InstrD[19:12], InstrD[20],
                      InstrD[30:21], 1'b0};
    endcase
  end

  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] rd1, rd2;

`ifdef RF_BYPASS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (RegWriteW && RdW != '0) begin
      rf[RdW] <= ResultW;
    end
  end
`else
  // Falling-edge write lets the same cycle's read see the new value.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (RegWriteW && RdW != '0) begin
      rf[RdW] <= ResultW;
    end
  end
`endif

  always_comb begin
    rd1 = (Rs1D == '0) ? '0 : rf[Rs1D];
    rd2 = (Rs2D == '0) ? '0 : rf[Rs2D];
`ifdef RF_BYPASS_EN
    if (RegWriteW && RdW != '0 && RdW == Rs1D) rd1 = ResultW;
    if (RegWriteW && RdW != '0 && RdW == Rs2D) rd2 = ResultW;
`endif
  end

  id_ex_t idex_d, idex_q;

  always_comb begin
    idex_d.reg_write  = reg_write;
    idex_d.result_src = result_src;
    idex_d.mem_write  = mem_write;
    idex_d.jump       = jump;
    idex_d.branch     = branch;
    idex_d.alu_ctrl   = alu_ctrl;
    idex_d.alu_src    = alu_src;
    idex_d.rd1        = rd1;
    idex_d.rd2        = rd2;
    idex_d.imm        = imm;
    idex_d.pc         = PCD;
    idex_d.pc4        = PCPlus4D;
    idex_d.rs1        = Rs1D;
    idex_d.rs2        = Rs2D;
    idex_d.rd         = InstrD[11:7];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         idex_q <= '0;
    else if (FlushE) idex_q <= '0;
    else             idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign ResultSrcE  = idex_q.result_src;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUControlE = idex_q.alu_ctrl;
  assign ALUSrcE     = idex_q.alu_src;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc4;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: random instructions against an
// arithmetic reference decoder and an array register-file model.
module tb_decode_stage;

  logic        clk, rst, FlushE;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW;
  logic [4:0]  RdW, Rs1D, Rs2D;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  decode_stage dut (
    .clk(clk), .rst(rst), .FlushE(FlushE),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [2:0]  alu_ctrl;
    logic        alu_src;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } idex_t;

  typedef struct packed {
    idex_t v;
    logic  imm_chk;
  } item_t;

  localparam logic [2:0] A_ADD = 3'b000, A_SUB = 3'b001;
  localparam logic [2:0] A_AND = 3'b010, A_OR  = 3'b011;
  localparam logic [2:0] A_SLT = 3'b101;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] regs [32];
  item_t       q [$];
  item_t       pend_item;
  logic        pend = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sext(input logic [31:0] v,
                                       input int n);
    logic [31:0] m, s;
    m = (32'd1 << n) - 32'd1;
    s = 32'd1 << (n - 1);
    return ((v & m) ^ s) - s;
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3,
                                        input logic sub_ok);
    case (f3)
      3'd0:    return sub_ok ? A_SUB : A_ADD;
      3'd2:    return A_SLT;
      3'd6:    return A_OR;
      3'd7:    return A_AND;
      default: return A_ADD;
    endcase
  endfunction

  function automatic idex_t model(input logic [31:0] i,
                                  input logic [31:0] pc,
                                  output logic chk);
    idex_t e;
    logic [31:0] u;
    e = '0;
    chk = 1'b1;
    u = i;
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd  = i[11:7];
    e.rd1 = regs[i[19:15]];
    e.rd2 = regs[i[24:20]];
    e.pc  = pc;
    e.pc4 = pc + 32'd4;
    case (i[6:0])
      7'h03: begin
        e.reg_write = 1; e.alu_src = 1; e.result_src = 2'd1;
        e.imm = sext(u >> 20, 12);
      end
      7'h23: begin
        e.mem_write = 1; e.alu_src = 1;
        e.imm = sext(((u >> 25) << 5) | ((u >> 7) & 32'h1f), 12);
      end
      7'h33: begin
        e.reg_write = 1; chk = 1'b0;
        e.alu_ctrl = alu_of(i[14:12], i[30]);
      end
      7'h13: begin
        e.reg_write = 1; e.alu_src = 1;
        e.imm = sext(u >> 20, 12);
        e.alu_ctrl = alu_of(i[14:12], 1'b0);
      end
      7'h63: begin
        e.branch = 1; e.alu_ctrl = A_SUB;
        e.imm = sext((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11)
                   | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
      end
      7'h6f: begin
        e.reg_write = 1; e.jump = 1; e.result_src = 2'd2;
        e.imm = sext((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12)
                   | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
      end
      default: chk = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic [2:0]  f3;
    i = $urandom;
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    i[11:7]  = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0: f3 = 3'd0;
      1: f3 = 3'd2;
      2: f3 = 3'd6;
      default: f3 = 3'd7;
    endcase
    case ($urandom_range(0, 6))
      0: i[6:0] = 7'h03;
      1: i[6:0] = 7'h23;
      2: begin
        i[6:0] = 7'h33; i[14:12] = f3;
        i[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      end
      3: begin i[6:0] = 7'h13; i[14:12] = f3; end
      4: i[6:0] = 7'h63;
      5: i[6:0] = 7'h6f;
      default: i[6:0] = $urandom_range(0, 1) ? 7'h37 : 7'h00;
    endcase
    return i;
  endfunction

  task automatic issue(input logic [31:0] ins, input logic we,
                       input logic [4:0] rd, input logic [31:0] res,
                       input logic fl);
    item_t it;
    logic  c;
    logic [31:0] pc;
    @(posedge clk);
    if (pend) begin q.push_back(pend_item); pend = 1'b0; end
    #1;
    pc = $urandom & ~32'd3;
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = we; RdW = rd; ResultW = res; FlushE = fl;
    if (we && rd != 5'd0) regs[rd] = res;
    if (fl) begin
      it.v = '0; it.imm_chk = 1'b1;
    end else begin
      it.v = model(ins, pc, c); it.imm_chk = c;
    end
    pend_item = it;
    pend = 1'b1;
    #1;
    checks++;
    if ({Rs1D, Rs2D} !== {ins[19:15], ins[24:20]}) begin
      errors++;
      $display("FAIL rs_comb: got %h/%h expected %h/%h",
               Rs1D, Rs2D, ins[19:15], ins[24:20]);
    end
  endtask

  function automatic idex_t act_idex();
    idex_t a;
    a.reg_write = RegWriteE; a.result_src = ResultSrcE;
    a.mem_write = MemWriteE; a.jump = JumpE; a.branch = BranchE;
    a.alu_ctrl = ALUControlE; a.alu_src = ALUSrcE;
    a.rd1 = RD1E; a.rd2 = RD2E; a.imm = ImmExtE;
    a.pc = PCE; a.pc4 = PCPlus4E;
    a.rs1 = Rs1E; a.rs2 = Rs2E; a.rd = RdE;
    return a;
  endfunction

  task automatic check_zero(input string nm);
    idex_t a;
    a = act_idex();
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL %s: got %h expected 0", nm, a);
    end
  endtask

  always @(negedge clk) begin
    item_t it;
    idex_t a;
    if (q.size() > 0) begin
      it = q.pop_front();
      a = act_idex();
      if (!it.imm_chk) a.imm = it.v.imm;
      checks++;
      if (a !== it.v) begin
        errors++;
        $display("FAIL idex: got %h expected %h", a, it.v);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    q.delete();
    pend = 1'b0;
    #1 rst = 1'b1;
    #1 check_zero("async_rst");
    for (int r = 0; r < 32; r++) regs[r] = '0;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic rand_cycle();
    logic [31:0] ins;
    logic [4:0]  rd;
    ins = rand_instr();
    rd = ($urandom_range(0, 3) == 0) ? ins[19:15]
                                     : 5'($urandom_range(0, 7));
    issue(ins, 1'($urandom_range(0, 1)), rd, $urandom,
          $urandom_range(0, 9) == 0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = '0;
    rst = 1'b1; FlushE = 0; InstrD = 0; PCD = 0; PCPlus4D = 0;
    RegWriteW = 0; RdW = 0; ResultW = 0;
    #2 check_zero("reset_state");
    @(negedge clk);
    #1 rst = 1'b0;

    issue(32'h00500093, 0, 0, 0, 0);
    issue(32'hFE208EE3, 0, 0, 0, 0);
    issue(32'h0000006F, 0, 0, 0, 0);
    issue(32'h00018213, 1, 5'd3, 32'hDEADBEEF, 0);
    issue(32'h003182B3, 0, 0, 0, 0);
    issue(32'h00000013, 1, 5'd0, 32'h00001234, 0);
    issue(32'h00000093, 0, 0, 0, 0);
    issue(32'h00302023, 1, 5'd2, 32'h0000BEEF, 1);
    issue(32'h00218233, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) rand_cycle();

    do_reset();
    for (int r = 1; r < 32; r++)
      issue((32'(r) << 15) | (32'(r) << 20) | 32'h000000B3,
            0, 0, 0, 0);

    for (int n = 0; n < 100; n++) rand_cycle();

    @(posedge clk);
    if (pend) begin q.push_back(pend_item); pend = 1'b0; end
    #1 FlushE = 1'b0; RegWriteW = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
